// File: rtl/linear_filter_mul_arbiter.sv
// rtl/linear_filter_mul_arbiter.sv - shared pipelined multiplier arbiter with tag return path (option: LINFILT_MUL_ARB_FIXED_PRIO_EN)
module linear_filter_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mul_ce,
    output logic [DATA_WIDTH-1:0]         mul_din0,
    output logic [DATA_WIDTH-1:0]         mul_din1,
    input  logic [DATA_WIDTH-1:0]         mul_dout,
    output logic                          busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tag stage s travels with the multiplier data; the last stage lines up with mul_dout
    logic [MUL_LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]       tag_idx [MUL_LATENCY];
    logic                   tail_valid;
    logic [IDX_W-1:0]       tail_idx;

    logic                   grant_valid;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       search_base;
    int                     cand;

    assign tail_valid = tag_valid[MUL_LATENCY-1];
    assign tail_idx   = tag_idx[MUL_LATENCY-1];

`ifdef LINFILT_MUL_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    logic [IDX_W-1:0] ptr;

    // Round-robin pointer moves just past the winner on every accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (mul_ce && grant_valid) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    assign search_base = ptr;
`endif

    // Scan requesters from search_base upward with wrap; first valid one wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(search_base) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Freeze everything while the finished product at the tail cannot be handed over
    always_comb begin
        mul_ce = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tail_valid && (tail_idx == IDX_W'(i)) && !rsp_ready[i]) begin
                mul_ce = 1'b0;
            end
        end
    end

    // Handshakes and operand mux; an idle slot feeds zeros as a bubble
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == IDX_W'(i))) begin
                mul_din0 = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                mul_din1 = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                if (mul_ce && reset_n) begin
                    req_ready[i] = 1'b1;
                end
            end
            if (tail_valid && (tail_idx == IDX_W'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    // Tag pipeline shifts in lock step with the multiplier enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_idx[s] <= '0;
            end
        end else if (mul_ce) begin
            tag_valid[0] <= grant_valid;
            tag_idx[0]   <= grant_idx;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
            end
        end
    end

    assign rsp_data = mul_dout;
    assign busy     = |tag_valid;

endmodule

// File: tb/tb_linear_filter_mul_arbiter.sv
// tb/tb_linear_filter_mul_arbiter.sv - scoreboard bench for linear_filter_mul_arbiter
module tb_linear_filter_mul_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        bit           gap;
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] p;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_rdy;
    logic [W-1:0]      rsp_data;
    logic              mul_ce;
    logic [W-1:0]      mul_din0;
    logic [W-1:0]      mul_din1;
    logic [W-1:0]      mul_dout;
    logic              busy;

    logic [W-1:0] a_v [NREQ];
    logic [W-1:0] b_v [NREQ];
    logic [W-1:0] exp_cur [NREQ];
    bit           acc [NREQ];
    bit           shown_gap [NREQ];
    vec_t         stim [NREQ][$];
    exp_t         sb [$];
    int           glog [$];

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int rv_seen = 0;
    int cyc = 0;
    int last_pop = 0;
    int c0, p0, r0;

    logic [W-1:0] m_r0, m_r1;

    linear_filter_mul_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(W), .MUL_LATENCY(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_rdy),
        .rsp_data  (rsp_data),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: input register then output register, both gated by ce
    always @(posedge clk) begin
        if (mul_ce) begin
            m_r0 <= mul_din0 * mul_din1;
            m_r1 <= m_r0;
        end
    end
    assign mul_dout = m_r1;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
        vec_t v;
        v.a = a; v.b = b; v.p = p; v.gap = 1'b0;
        return v;
    endfunction

    function automatic vec_t gapv();
        vec_t v;
        v.a = '0; v.b = '0; v.p = '0; v.gap = 1'b1;
        return v;
    endfunction

    // Driver: retire accepted or shown-gap entries, then present the next vector
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (stim[i].size() > 0 && (stim[i][0].gap ? shown_gap[i] : acc[i]))
                stim[i].delete(0);
            shown_gap[i] = 1'b0;
            if (stim[i].size() == 0) begin
                req_valid[i] = 1'b0;
                a_v[i] = '0;
                b_v[i] = '0;
            end else if (stim[i][0].gap) begin
                req_valid[i] = 1'b0;
                shown_gap[i] = 1'b1;
            end else begin
                req_valid[i] = 1'b1;
                a_v[i] = stim[i][0].a;
                b_v[i] = stim[i][0].b;
                exp_cur[i] = stim[i][0].p;
            end
        end
    end

    // Issue side: every accepted request pushes its hand-computed product
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) acc[i] = req_ready[i];
        if (req_ready != '0) begin
            chk("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    chk("req_ready_has_valid", 64'(req_valid[i]), 64'd1);
                    sb.push_back('{idx: i, p: exp_cur[i]});
                    glog.push_back(i);
                end
            end
        end
    end

    // Response monitor: pop and compare on every delivered product
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            rv_seen++;
            chk("rsp_valid_onehot", 64'($countones(rsp_valid)), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i] && rsp_rdy[i]) begin
                    if (sb.size() == 0) begin
                        chk("rsp_spurious", 64'(i), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_idx", 64'(i), 64'(e.idx));
                        chk("rsp_data", 64'(rsp_data), 64'(e.p));
                        n_pop++;
                        last_pop = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_pops(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (n_pop < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(n_pop), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rr_exp [12];
`ifdef LINFILT_MUL_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`else
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
        reset_n = 1'b0;
        rsp_rdy = '1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0; b_v[i] = '0; exp_cur[i] = '0; acc[i] = 1'b0; shown_gap[i] = 1'b0;
        end

        // Reset state with a request already pending on requester 1
        @(negedge clk);
        stim[1].push_back(mk(32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB));
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mul_ce", 64'(mul_ce), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);

        // Single request latency and busy window
        @(posedge clk); #2;
        reset_n = 1'b1;
        c0 = cyc; p0 = n_pop;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'b0010);
        @(negedge clk);
        chk("single_busy_c1", 64'(busy), 64'd1);
        chk("single_rsp_c1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_rsp_c2", 64'(rsp_valid), 64'b0010);
        chk("single_busy_c2", 64'(busy), 64'd1);
        @(negedge clk);
        chk("single_busy_c3", 64'(busy), 64'd0);
        chk("single_count", 64'(n_pop - p0), 64'd1);
        chk("single_latency", 64'(last_pop - c0), 64'd2);

        // Reset mid-flight: two accepted requests are discarded
        @(negedge clk);
        r0 = rv_seen;
        stim[0].push_back(mk(32'd3, 32'd3, 32'd9));
        stim[1].push_back(mk(32'd2, 32'd2, 32'd4));
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_mul_ce", 64'(mul_ce), 64'd1);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_busy_after", 64'(busy), 64'd0);
        chk("midrst_no_rsp", 64'(rv_seen - r0), 64'd0);

        // Round-robin across all four, starting from pointer 0
        @(negedge clk);
        c0 = cyc; p0 = n_pop;
        glog.delete();
        stim[0].push_back(mk(32'd2, 32'd3, 32'd6));
        stim[0].push_back(mk(32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB));
        stim[0].push_back(mk(32'd100, 32'd100, 32'h0000_2710));
        stim[1].push_back(mk(32'd4, 32'd4, 32'h10));
        stim[1].push_back(mk(32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'h10));
        stim[1].push_back(mk(32'h0001_0000, 32'h0001_0000, 32'h0));
        stim[2].push_back(mk(32'd9, 32'd9, 32'h51));
        stim[2].push_back(mk(32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFEB));
        stim[2].push_back(mk(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE));
        stim[3].push_back(mk(32'd1, 32'd1, 32'd1));
        stim[3].push_back(mk(32'd0, 32'd55, 32'd0));
        stim[3].push_back(mk(32'd12, 32'hFFFF_FFF4, 32'hFFFF_FF70));
        wait_pops("rr_count", p0 + 12, 60);
        chk("rr_drain_cycles", 64'(last_pop - c0), 64'd14);
        chk("rr_grant_count", 64'(glog.size()), 64'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < glog.size()) chk($sformatf("rr_grant_%0d", k), 64'(glog[k]), 64'(rr_exp[k]));
        end

        // Backpressure on requester 2 for three cycles
        @(negedge clk);
        c0 = cyc; p0 = n_pop;
        stim[2].push_back(mk(32'd5, 32'd6, 32'h1E));
        stim[2].push_back(mk(32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd9));
        stim[2].push_back(mk(32'h100, 32'h100, 32'h0001_0000));
        stim[2].push_back(mk(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF));
        stim[2].push_back(mk(32'd11, 32'd13, 32'h8F));
        repeat (3) @(posedge clk);
        #2;
        rsp_rdy[2] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk($sformatf("bp_mul_ce_%0d", s), 64'(mul_ce), 64'd0);
            chk($sformatf("bp_req_ready_%0d", s), 64'(req_ready), 64'd0);
            chk($sformatf("bp_rsp_valid_%0d", s), 64'(rsp_valid), 64'b0100);
            chk($sformatf("bp_rsp_data_%0d", s), 64'(rsp_data), 64'h1E);
        end
        @(posedge clk);
        #2;
        rsp_rdy[2] = 1'b1;
        wait_pops("bp_count", p0 + 5, 60);
        chk("bp_drain_cycles", 64'(last_pop - c0), 64'd10);

        // Overflow wraps to the low product bits
        @(negedge clk);
        c0 = cyc; p0 = n_pop;
        stim[0].push_back(mk(32'h4000_0000, 32'd4, 32'h0));
        stim[0].push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        wait_pops("ovf_count", p0 + 2, 40);
        chk("ovf_drain_cycles", 64'(last_pop - c0), 64'd4);

        // Alternating valid/idle cycles on requester 3
        @(negedge clk);
        c0 = cyc; p0 = n_pop; r0 = rv_seen;
        stim[3].push_back(mk(32'd6, 32'd7, 32'h2A));
        stim[3].push_back(gapv());
        stim[3].push_back(mk(32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFEC));
        stim[3].push_back(gapv());
        stim[3].push_back(mk(32'd8, 32'd8, 32'h40));
        wait_pops("bubble_count", p0 + 3, 40);
        chk("bubble_drain_cycles", 64'(last_pop - c0), 64'd7);
        repeat (3) @(negedge clk);
        chk("bubble_valid_cycles", 64'(rv_seen - r0), 64'd3);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
